// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: 2W-bit dividend / W-bit divisor,
// one quotient bit per clock, valid/ready on both sides.
module seq_divider #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           err
);
  localparam int CW = $clog2(W + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [W-1:0]  r_div;
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_q;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_quot;
  logic [W-1:0]  r_remout;
  logic          r_err;

  logic          w_ovf;
  logic [W:0]    w_shift;
  logic          w_ge;
  logic [W-1:0]  w_sub;
  logic [W-1:0]  w_rnext;
  logic [W-1:0]  w_qnext;

  // High half >= divisor means the quotient cannot fit (also catches /0).
  assign w_ovf = dividend[2*W-1:W] >= divisor;

  // The partial remainder is always < divisor between steps, so W stored bits
  // suffice; only the shifted value needs the extra bit.
  assign w_shift = {r_rem, r_q[W-1]};
  assign w_ge    = w_shift >= {1'b0, r_div};
  assign w_sub   = w_shift[W-1:0] - r_div;
  assign w_rnext = w_ge ? w_sub : w_shift[W-1:0];
  assign w_qnext = {r_q[W-2:0], w_ge};

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign quotient  = r_quot;
  assign remainder = r_remout;
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_quot   <= '0;
      r_remout <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_div <= divisor;
            if (w_ovf) begin
              r_state  <= S_DONE;
              r_err    <= 1'b1;
              r_quot   <= '1;
              r_remout <= dividend[W-1:0];
            end else begin
              r_rem   <= dividend[2*W-1:W];
              r_q     <= dividend[W-1:0];
              r_cnt   <= CW'(W);
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rnext;
          r_q   <= w_qnext;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state  <= S_DONE;
            r_err    <= 1'b0;
            r_quot   <= w_qnext;
            r_remout <= w_rnext;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
